mem_stage_ctrl: RTL and testbench

- Sequences data-memory accesses in the MEM stage of the MIPS32 pipeline.
- Sits between the EX/MEM register and a variable-latency data memory with a req/ack handshake.
- Stalls the pipeline while an access is outstanding, then hands read data and a completion pulse to the MEM/WB register.
- Non-memory instructions pass through with zero added latency.

---
 rtl/mem_stage_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl -- MEM-stage data-memory access sequencer (MIPS32 pipeline).
//
// Sits between the EX/MEM register and a variable-latency data memory using a
// req/ack handshake. A memory instruction stalls the front of the pipeline
// while its access is outstanding, then presents read data with a one-cycle
// done pulse toward MEM/WB. Non-memory instructions see zero added latency.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : WAIT is bounded by TIMEOUT cycles; expiry aborts with err_o.
//   undefined : WAIT lasts until ack; err_o reports misalignment only.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   ex_valid_i    EX/MEM holds a valid instruction
//   ctrl_i[7:0]   control bus; bit4 mem_read_en, bit5 mem_write_en
//   addr_i        access address (ALU result)
//   wdata_i       store data
//   mem_req_o     memory request, held until ack
//   mem_we_o      1 = write, 0 = read
//   mem_addr_o    latched address
//   mem_wdata_o   latched store data
//   mem_ack_i     memory completion pulse
//   mem_rdata_i   read data, valid with mem_ack_i
//   stall_o       freeze PC, IF/ID, ID/EX, EX/MEM
//   rdata_o       load result toward MEM/WB (held until next completion)
//   done_o        one-cycle pulse: access finished
//   err_o         one-cycle pulse: access aborted
module mem_stage_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [7:0]        ctrl_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              acc;
  logic              timeout_hit;

  assign acc = ex_valid_i & (ctrl_i[4] | ctrl_i[5]);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter holds zero outside WAIT, so it is already cleared on entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT) cnt_d = cnt_q + 1'b1;
  end

  // cnt_q counts completed WAIT cycles, so TIMEOUT-1 marks the last allowed one.
  assign timeout_hit = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  logic unused;
  assign unused = ^{ctrl_i[7:6], ctrl_i[3:0]};
`else
  localparam logic [31:0] TIMEOUT_U = TIMEOUT;

  assign timeout_hit = 1'b0;

  logic unused;
  assign unused = ^{ctrl_i[7:6], ctrl_i[3:0], TIMEOUT_U[0]};
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (addr_i[1:0] == 2'b00) begin
            state_d = WAIT;
            req_d   = 1'b1;
            we_d    = ctrl_i[5];
            addr_d  = addr_i;
            wdata_d = wdata_i;
            err_d   = 1'b0;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      WAIT: begin
        // Ack takes priority over a coincident timeout.
        if (mem_ack_i) begin
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : mem_rdata_i;
        end else if (timeout_hit) begin
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;
  assign stall_o     = ((state_q == IDLE) && acc) || (state_q == WAIT);
  assign done_o      = (state_q == DONE);
  assign err_o       = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: a driver plays the EX/MEM register, a
// responder plays a memory with per-request latency, and a monitor pops the
// expected completion whenever done_o is presented.
module tb_mem_stage_ctrl;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_valid_i = 1'b0;
  logic [7:0]    ctrl_i = '0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] wdata_i = '0;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          stall_o;
  logic [DW-1:0] rdata_o;
  logic          done_o, err_o;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ctrl_i(ctrl_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o),
    .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { logic [31:0] rdata; logic err; } cpl_t;

  req_t        req_q[$];
  cpl_t        cpl_q[$];
  int          lat_q[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] sim_mem   [logic [31:0]];
  logic [31:0] last_rdata = '0;
  bit          spur_force = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Memory responder: acks the lat-th WAIT cycle of each request, checks the
  // request fields every cycle, and throws spurious acks while idle.
  initial begin
    bit   active = 1'b0;
    bit   served = 1'b0;
    int   cnt = 0;
    int   lat = 1;
    req_t r;
    forever begin
      @(negedge clk);
      mem_ack_i   = 1'b0;
      mem_rdata_i = $urandom;
      if (mem_req_o) begin
        if (!active) begin
          active = 1'b1;
          served = 1'b0;
          cnt    = 0;
          if (lat_q.size() == 0) begin fail("req_unexpected"); lat = 1; end
          else lat = lat_q.pop_front();
        end
        cnt++;
        if (!served) begin
          if (req_q.size() == 0) fail("req_no_expect");
          else begin
            r = req_q[0];
            check("req_we",    {31'd0, mem_we_o}, {31'd0, r.we});
            check("req_addr",  mem_addr_o,  r.addr);
            check("req_wdata", mem_wdata_o, r.wdata);
          end
          if (cnt == lat) begin
            mem_ack_i = 1'b1;
            if (mem_we_o) sim_mem[mem_addr_o] = mem_wdata_o;
            else mem_rdata_i = sim_mem.exists(mem_addr_o) ? sim_mem[mem_addr_o] : dflt(mem_addr_o);
            if (req_q.size() > 0) void'(req_q.pop_front());
            served = 1'b1;
          end
        end
      end else begin
        if (active && !served && req_q.size() > 0) void'(req_q.pop_front());
        active = 1'b0;
        if (spur_force || $urandom_range(0, 3) == 0) mem_ack_i = 1'b1;
      end
    end
  end

  // Completion monitor.
  initial begin
    cpl_t c;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done_o) begin
          if (cpl_q.size() == 0) fail("done_unexpected");
          else begin
            c = cpl_q.pop_front();
            check("cpl_rdata", rdata_o, c.rdata);
            check("cpl_err", {31'd0, err_o}, {31'd0, c.err});
            last_rdata = c.rdata;
          end
        end else begin
          check("err_without_done", {31'd0, err_o}, 32'd0);
          check("rdata_hold", rdata_o, last_rdata);
        end
      end
    end
  end

  // Presents one instruction at a negedge, holds it while stalled, and
  // checks the number of stalled cycles against the access latency model.
  task automatic issue(input logic v, input logic [7:0] c, input logic [31:0] a,
                       input logic [31:0] w, input int lat);
    logic acc;
    bit   timed;
    int   exp_stall;
    int   n;
    acc = v & (c[4] | c[5]);
    exp_stall = 0;
    if (acc) begin
      if (a[1:0] != 2'b00) begin
        cpl_q.push_back('{32'd0, 1'b1});
        exp_stall = 1;
      end else begin
`ifdef MEM_TIMEOUT_EN
        timed = (lat > TMO);
`else
        timed = 1'b0;
`endif
        lat_q.push_back(lat);
        req_q.push_back('{c[5], a, w});
        if (timed) begin
          cpl_q.push_back('{32'd0, 1'b1});
          exp_stall = 1 + TMO;
        end else begin
          if (c[5]) begin
            model_mem[a] = w;
            cpl_q.push_back('{32'd0, 1'b0});
          end else begin
            cpl_q.push_back('{model_mem.exists(a) ? model_mem[a] : dflt(a), 1'b0});
          end
          exp_stall = 1 + lat;
        end
      end
    end
    ex_valid_i = v;
    ctrl_i     = c;
    addr_i     = a;
    wdata_i    = w;
    #1;
    n = 0;
    while (stall_o && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", n, exp_stall);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  c;
    int          maxlat;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   {31'd0, mem_req_o}, 32'd0);
    check("rst_we",    {31'd0, mem_we_o},  32'd0);
    check("rst_addr",  mem_addr_o,  32'd0);
    check("rst_wdata", mem_wdata_o, 32'd0);
    check("rst_rdata", rdata_o,     32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_done",  {31'd0, done_o},  32'd0);
    check("rst_err",   {31'd0, err_o},   32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    model_mem[32'h100] = 32'hCAFE_F00D;
    sim_mem[32'h100]   = 32'hCAFE_F00D;
    issue(1'b1, 8'h10, 32'h100, 32'h0, 3);
    issue(1'b1, 8'h20, 32'h204, 32'h1234_5678, 1);
    issue(1'b1, 8'h10, 32'h102, 32'h0, 1);
    issue(1'b1, 8'h08, 32'h000, 32'h0, 1);
    issue(1'b1, 8'h10, 32'h204, 32'h0, 2);
    issue(1'b1, 8'h10, 32'h100, 32'h0, 1);
    issue(1'b1, 8'h30, 32'h208, 32'hDEAD_BEEF, 2);
    issue(1'b1, 8'h10, 32'h208, 32'h0, 1);
    issue(1'b0, 8'h10, 32'h100, 32'h0, 1);
    issue(1'b1, 8'h20, 32'h301, 32'h1, 1);
`ifdef MEM_TIMEOUT_EN
    issue(1'b1, 8'h10, 32'h100, 32'h0, 10);
    issue(1'b1, 8'h10, 32'h100, 32'h0, TMO);
    issue(1'b1, 8'h20, 32'h100, 32'h7777_0000, 9);
    issue(1'b1, 8'h10, 32'h100, 32'h0, 1);
    maxlat = TMO + 3;
`else
    maxlat = 5;
`endif

    // Randomized instruction stream over a small address window.
    for (int i = 0; i < 200; i++) begin
      a = 32'h1000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      c = 8'($urandom);
      issue($urandom_range(0, 7) != 0, c, a, $urandom, $urandom_range(1, maxlat));
    end

    // Reset during WAIT, followed by acks that must be ignored.
    lat_q.push_back(50);
    req_q.push_back('{1'b0, 32'h300, 32'h0});
    ex_valid_i = 1'b1;
    ctrl_i     = 8'h10;
    addr_i     = 32'h300;
    wdata_i    = 32'h0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst        = 1'b1;
    ex_valid_i = 1'b0;
    spur_force = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_req",   {31'd0, mem_req_o}, 32'd0);
    check("midrst_we",    {31'd0, mem_we_o},  32'd0);
    check("midrst_addr",  mem_addr_o,  32'd0);
    check("midrst_rdata", rdata_o,     32'd0);
    check("midrst_stall", {31'd0, stall_o}, 32'd0);
    check("midrst_done",  {31'd0, done_o},  32'd0);
    last_rdata = 32'd0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (6) @(negedge clk);
    spur_force = 1'b0;
    check("postrst_req", {31'd0, mem_req_o}, 32'd0);

    repeat (4) @(negedge clk);
    check("cpl_queue_empty", cpl_q.size(), 32'd0);
    check("req_queue_empty", req_q.size(), 32'd0);
    check("lat_queue_empty", lat_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
